// File: rtl/alu_cmd_ctrl_if.sv
// alu_cmd_ctrl_if: command, ALU operand/result and response signals of alu_cmd_ctrl.
// master = command driver / ALU side, slave = the controller.
interface alu_cmd_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_ld;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_srca;
    logic [1:0]  cmd_srcb;
    logic [1:0]  cmd_dst;
    logic        cmd_cin;
    logic [15:0] cmd_imm;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_c;
    logic [2:0]  alu_opc;
    logic [15:0] alu_w;
    logic        alu_zer;
    logic        alu_neg;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zer;
    logic        rsp_neg;
    logic        rsp_err;
    modport master (
        output cmd_valid, cmd_ld, cmd_op, cmd_srca, cmd_srcb, cmd_dst, cmd_cin, cmd_imm,
        output alu_w, alu_zer, alu_neg, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_c, alu_opc,
        input  rsp_valid, rsp_data, rsp_zer, rsp_neg, rsp_err
    );
    modport slave (
        input  cmd_valid, cmd_ld, cmd_op, cmd_srca, cmd_srcb, cmd_dst, cmd_cin, cmd_imm,
        input  alu_w, alu_zer, alu_neg, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_c, alu_opc,
        output rsp_valid, rsp_data, rsp_zer, rsp_neg, rsp_err
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: command controller for the 16-bit ALU with a 4-entry register file.
// Define ALU_CMD_CTRL_OPCHK_EN to reject opcode 3'b111 with rsp_err instead of issuing it.
module alu_cmd_ctrl #(
    parameter logic [15:0] REG_INIT = 16'h0000
) (
    input logic           clk,
    input logic           rst,
    alu_cmd_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t      r_state;
    logic [15:0] r_regs [4];
    logic [1:0]  r_dst;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_zer;
    logic        r_rsp_neg;
    logic        r_rsp_err;
    logic [15:0] r_alu_a;
    logic [15:0] r_alu_b;
    logic        r_alu_c;
    logic [2:0]  r_alu_opc;
    logic        w_reject;
`ifdef ALU_CMD_CTRL_OPCHK_EN
    assign w_reject = bus.cmd_op == 3'b111;
`else
    assign w_reject = 1'b0;
`endif
    assign bus.cmd_ready = r_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zer   = r_rsp_zer;
    assign bus.rsp_neg   = r_rsp_neg;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_c     = r_alu_c;
    assign bus.alu_opc   = r_alu_opc;
    // Operands are latched straight into the ALU drive registers, so reads are pre-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dst       <= 2'd0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 16'h0000;
            r_rsp_zer   <= 1'b0;
            r_rsp_neg   <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_alu_a     <= 16'h0000;
            r_alu_b     <= 16'h0000;
            r_alu_c     <= 1'b0;
            r_alu_opc   <= 3'b111;
            for (int i = 0; i < 4; i++) r_regs[i] <= REG_INIT;
        end else begin
            case (r_state)
                IDLE: if (bus.cmd_valid) begin
                    r_dst       <= bus.cmd_dst;
                    r_cmd_ready <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    if (bus.cmd_ld) begin
                        r_regs[bus.cmd_dst] <= bus.cmd_imm;
                        r_rsp_data  <= bus.cmd_imm;
                        r_rsp_zer   <= bus.cmd_imm == 16'h0000;
                        r_rsp_neg   <= bus.cmd_imm[15];
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else if (w_reject) begin
                        r_rsp_err   <= 1'b1;
                        r_rsp_data  <= 16'h0000;
                        r_rsp_zer   <= 1'b0;
                        r_rsp_neg   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_alu_a   <= r_regs[bus.cmd_srca];
                        r_alu_b   <= r_regs[bus.cmd_srcb];
                        r_alu_c   <= bus.cmd_cin;
                        r_alu_opc <= bus.cmd_op;
                        r_state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_regs[r_dst] <= bus.alu_w;
                    r_rsp_data    <= bus.alu_w;
                    r_rsp_zer     <= bus.alu_zer;
                    r_rsp_neg     <= bus.alu_neg;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command-side controller for the 16-bit combinational ALU: accepts register-level commands over a valid/ready interface, reads operands from a local 4-entry register file, and drives `inA`/`inB`/`inC`/`opc` to the ALU. It captures `outW`/`zer`/`neg`, writes the result back to the register file, and returns it over a valid/ready response interface. It sits between the instruction/test driver and the ALU, forming the initiator end of the ALU's operand/result interface.

## Interface
- `REG_INIT`, 16'h0000, reset value of every register-file entry.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_ld`  in  1  1 = load immediate into `cmd_dst`; 0 = ALU operation.
- `cmd_op`  in  3  ALU opcode forwarded to `alu_opc`.
- `cmd_srca`, `cmd_srcb`  in  2 each  register-file read addresses.
- `cmd_dst`  in  2  register-file write address.
- `cmd_cin`  in  1  carry-in, forwarded to `alu_c`.
- `cmd_imm`  in  16  immediate value for `cmd_ld`.
- `alu_a`, `alu_b`  out  16 each  ALU operand A and B.
- `alu_c`  out  1  ALU carry-in.
- `alu_opc`  out  3  ALU opcode.
- `alu_w`  in  16  ALU result.
- `alu_zer`, `alu_neg`  in  1 each  ALU zero and negative flags.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  16  result value.
- `rsp_zer`, `rsp_neg`  out  1 each  result flags.
- `rsp_err`  out  1  command rejected (see Configuration).

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid & cmd_ready`, latch the op, dst, cin, imm, and the register-file contents at srca/srcb.
  - Read values are pre-write: srca, srcb, and dst may alias freely.
  - If `cmd_ld`=1, go to RESP. Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - `alu_a`/`alu_b`/`alu_c`/`alu_opc` present the latched operands.
  - At the closing edge, sample `alu_w`/`alu_zer`/`alu_neg` into the `rsp_*` registers and write `alu_w` to reg[dst].
  - Go to RESP.
- Load-immediate path:
  - At the accept edge, write `imm` to reg[dst] and load `rsp_data`=imm.
  - `rsp_zer` = (imm==0); `rsp_neg` = imm[15]. Both are computed locally; the ALU is not used.
- RESP:
  - `rsp_valid`=1 and `cmd_ready`=0.
  - `rsp_*` hold stable until `rsp_valid & rsp_ready`, then go to IDLE.
- ALU outputs hold their last driven values outside ISSUE. They change only at the accept edge of an ALU command.
- ALU opcode semantics (expected results):
  - 000: ~A+1
  - 001: A+1
  - 010: A+B+cin
  - 011: A+(B>>1)
  - 100: A&B
  - 101: A|B
  - 110: {A[7:0],B[7:0]}
  - 111: 0
- All arithmetic is 16-bit modulo 2^16; the controller does not widen or check carries.

## Timing
- Reset values:
  - `cmd_ready`=1, `rsp_valid`=0, `rsp_err`=0.
  - `rsp_data`=0, `rsp_zer`=0, `rsp_neg`=0.
  - `alu_a`=0, `alu_b`=0, `alu_c`=0, `alu_opc`=3'b111.
  - All registers = `REG_INIT`.
- ALU command accepted at edge T: ISSUE during T..T+1; `rsp_valid`=1 from edge T+2.
- Load command accepted at edge T: `rsp_valid`=1 from edge T+1.
- Response consumed at edge R: `cmd_ready`=1 from R+1. Maximum throughput is one ALU command per 3 cycles, or one load per 2 cycles.
- `rsp_ready` may be high before `rsp_valid`; the handshake completes on the first RESP cycle.
- `rsp_ready` low stalls indefinitely with all outputs stable.
- Register write from command N is visible to command N+1 (N+1 is accepted strictly after N's response).
- `rst` asserted in any state:
  - Immediate return to reset values.
  - Pending response discarded; an in-flight write-back does not occur.

## Configuration
- `ALU_CMD_CTRL_OPCHK_EN` defined:
  - An ALU command with `cmd_op`=3'b111 skips ISSUE and goes to RESP with `rsp_err`=1, `rsp_data`=0, `rsp_zer`=0, `rsp_neg`=0.
  - The register file is not written.
  - ALU outputs are not updated.
  - `rsp_err` is cleared on the next accepted command.
- Undefined:
  - Opcode 3'b111 is issued like any other opcode; reg[dst] and `rsp_data` receive 0 from the ALU (`rsp_zer`=1).
  - `rsp_err` is tied to 0.

## Test plan
- Load reg0=0x0005, then op 001 with srca=0, dst=1 -> load response at T+1 with data 0x0005; ALU response at T+2 with `rsp_data`=0x0006, zer=0, neg=0; reg1=0x0006.
- Op 000 with A=0x0005 -> `rsp_data`=0xFFFB, neg=1. Op 100 with 0x00F0 & 0x0F00 -> `rsp_data`=0x0000, zer=1.
- Op 010 with A=0x0005, B=0x000A, cin=1 -> 0x0010. Op 011, same operands -> 0x000A. Op 110 with A=0x1234, B=0xABCD -> 0x34CD.
- Aliasing: srca=srcb=dst=2 with reg2=0x0003, op 010, cin=0 -> 0x0006 written to reg2. The next op 001 on reg2 -> 0x0007.
- Backpressure: hold `rsp_ready`=0 for 5 cycles -> `rsp_*` stable, `cmd_ready`=0 throughout, `cmd_valid` ignored. Raise `rsp_ready` -> `cmd_ready`=1 next cycle.
- Assert `rst` during ISSUE -> `rsp_valid` never rises, the dst register equals `REG_INIT`, `alu_opc`=3'b111. With `ALU_CMD_CTRL_OPCHK_EN`: op 111 -> `rsp_err`=1, data 0x0000, dst register unchanged.
